// File: rtl/fifo_pkg.sv
// Constants and types shared by the FIFO control FSM, the storage stage and the top level.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;

    typedef logic [$clog2(FIFO_DEPTH)-1:0] ptr_t;
    typedef logic [$clog2(FIFO_DEPTH):0]   cnt_t;

endpackage

// File: rtl/fifo_buffer_if.sv
// Strobe/data/status bundle between the FIFO control FSM (master) and the storage stage (slave).
interface fifo_buffer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
);

    logic                    wen;
    logic                    ren;
    logic [DATA_WIDTH-1:0]   din;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output wen, ren, din,
        input  dout, full, empty, count, overflow, underflow
    );

    modport slave (
        input  wen, ren, din,
        output dout, full, empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Reset-to-zero wrapping pointer; DEPTH is a power of two so the natural rollover is the wrap.
module fifo_ptr #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PW = $clog2(DEPTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_buffer.sv
// FIFO storage stage: in-order word store with registered read, occupancy count and sticky error flags.
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic          clock,
    input  logic          reset,
    fifo_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status comes straight off the registered count, so it cannot glitch.
    assign bus.full      = (count_q == CW'(DEPTH));
    assign bus.empty     = (count_q == '0);
    assign bus.count     = count_q;
    assign bus.dout      = dout_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    assign wr_acc = bus.wen & ~bus.full;
    assign rd_acc = bus.ren & ~bus.empty;

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    // No reset on the array so it can map onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wen & bus.full) begin
                overflow_q <= 1'b1;
            end
            if (bus.ren & bus.empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: directed scenarios plus random traffic against a queue-based reference model.
module tb_fifo_buffer;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int DP = 8;

    logic clock;
    logic reset;

    fifo_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] mdl_dout;
    logic          mdl_ovf;
    logic          mdl_unf;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".count"},     32'(bus.count),     32'(mdl_q.size()));
        check_val({tag, ".full"},      32'(bus.full),      32'(mdl_q.size() == DP));
        check_val({tag, ".empty"},     32'(bus.empty),     32'(mdl_q.size() == 0));
        check_val({tag, ".dout"},      32'(bus.dout),      32'(mdl_dout));
        check_val({tag, ".overflow"},  32'(bus.overflow),  32'(mdl_ovf));
        check_val({tag, ".underflow"}, 32'(bus.underflow), 32'(mdl_unf));
    endtask

    // One clock: drive, advance the model at the edge, then compare shortly after.
    task automatic step(input logic rst, input logic w, input logic r, input logic [DW-1:0] d,
                        input string tag);
        bit was_full;
        bit was_empty;
        reset   = rst;
        bus.wen = w;
        bus.ren = r;
        bus.din = d;
        @(posedge clock);
        if (rst) begin
            mdl_q.delete();
            mdl_dout = '0;
            mdl_ovf  = 1'b0;
            mdl_unf  = 1'b0;
        end else begin
            was_full  = (mdl_q.size() == DP);
            was_empty = (mdl_q.size() == 0);
            if (w && was_full)  mdl_ovf = 1'b1;
            if (r && was_empty) mdl_unf = 1'b1;
            if (r && !was_empty) mdl_dout = mdl_q.pop_front();
            if (w && !was_full)  mdl_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        mdl_dout = '0;
        mdl_ovf  = 1'b0;
        mdl_unf  = 1'b0;
        reset    = 1'b1;
        bus.wen  = 1'b0;
        bus.ren  = 1'b0;
        bus.din  = '0;

        // Reset for two cycles.
        step(1, 0, 0, 8'h00, "rst0");
        step(1, 0, 0, 8'h00, "rst1");
        check_val("rst.empty", 32'(bus.empty), 1);
        check_val("rst.dout", 32'(bus.dout), 0);

        // Fill to full, then one write too many.
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(8'h11 * i), "fill");
        check_val("fill.count", 32'(bus.count), 8);
        check_val("fill.full", 32'(bus.full), 1);
        step(0, 1, 0, 8'h99, "ovf");
        check_val("ovf.count", 32'(bus.count), 8);
        check_val("ovf.flag", 32'(bus.overflow), 1);

        // Drain in order, then one read too many.
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 8'h00, "drain");
            check_val("drain.dout", 32'(bus.dout), 32'(8'h11 * i));
        end
        check_val("drain.empty", 32'(bus.empty), 1);
        step(0, 0, 1, 8'h00, "unf");
        check_val("unf.flag", 32'(bus.underflow), 1);
        check_val("unf.dout", 32'(bus.dout), 32'h88);

        // Pointer wrap.
        step(1, 0, 0, 8'h00, "rst2");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h30 + i), "wrap.w5");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h00, "wrap.r5");
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'(8'hA0 + i), "wrap.w6");
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 8'h00, "wrap.r6");
            check_val("wrap.dout", 32'(bus.dout), 32'(8'hA0 + i));
        end

        // Simultaneous write and read: mid, full, empty.
        step(1, 0, 0, 8'h00, "rst3");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'hC0 + i), "sim.w3");
        step(0, 1, 1, 8'hC3, "sim.mid");
        check_val("sim.mid.count", 32'(bus.count), 3);
        check_val("sim.mid.dout", 32'(bus.dout), 32'hC0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hD0 + i), "sim.fill");
        step(0, 1, 1, 8'hEE, "sim.full");
        check_val("sim.full.count", 32'(bus.count), 7);
        check_val("sim.full.ovf", 32'(bus.overflow), 1);
        step(1, 0, 0, 8'h00, "rst4");
        step(0, 1, 1, 8'h77, "sim.empty");
        check_val("sim.empty.count", 32'(bus.count), 1);
        check_val("sim.empty.unf", 32'(bus.underflow), 1);
        check_val("sim.empty.dout", 32'(bus.dout), 0);

        // Reset in the middle of a write burst.
        step(1, 0, 0, 8'h00, "rst5");
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h40 + i), "burst");
        step(1, 1, 0, 8'h44, "burst.rst");
        check_val("burst.rst.count", 32'(bus.count), 0);
        check_val("burst.rst.empty", 32'(bus.empty), 1);
        step(0, 1, 0, 8'h5A, "post.w");
        step(0, 0, 1, 8'h00, "post.r");
        check_val("post.dout", 32'(bus.dout), 32'h5A);

        // Random traffic with occasional reset.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 8'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
